rr_arbiter_4ch: RTL and testbench

- 4-requester round-robin arbiter that sits directly upstream of the 2-to-4 enabled decoder.
- Produces a 2-bit encoded grant index (feeds decoder `in`) and a grant-enable (feeds decoder `en`); the decoder then generates the one-hot grant lines.
- Enforces break-before-make: at least one all-zero decoder cycle between any two grants.
- Bounds grant tenure with a hold timeout.

---
 rtl/rr_arbiter_4ch_if.sv | 25 ++
 rtl/rr_arbiter_4ch.sv | 102 ++++++++++
 tb/tb_rr_arbiter_4ch.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4ch_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter side (master) drives the encoded grant; requesters (slave) drive req.
interface rr_arbiter_4ch_if;
  logic [3:0] req;
  logic [1:0] grant_idx;
  logic       grant_en;
  logic       forced_rel;
  logic       busy;

  modport master (
    input  req,
    output grant_idx,
    output grant_en,
    output forced_rel,
    output busy
  );

  modport slave (
    output req,
    input  grant_idx,
    input  grant_en,
    input  forced_rel,
    input  busy
  );
endinterface

// File: rtl/rr_arbiter_4ch.sv
// 4-way round-robin arbiter with break-before-make gap and hold timeout; grant one cycle after req.
// No backpressure: requesters hold req level-high; a grant ends on release or after MAX_HOLD cycles.
module rr_arbiter_4ch #(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_arbiter_4ch_if.master   arb
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       idx_q, idx_d;
  logic             en_q, en_d;
  logic             frc_q, frc_d;

  logic [1:0]       cand;
  logic [1:0]       sel;
  logic             found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 2'b11;
      idx_q   <= 2'b00;
      en_q    <= 1'b0;
      frc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      frc_q   <= frc_d;
    end
  end

  // Cyclic search starting just after the last served channel.
  always_comb begin
    cand  = 2'b00;
    sel   = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && arb.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    idx_d   = idx_q;
    en_d    = en_q;
    frc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (found) begin
          idx_d   = sel;
          last_d  = sel;
          en_d    = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release wins over timeout when both land on the same edge.
        if (!arb.req[idx_q]) begin
          en_d    = 1'b0;
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          en_d    = 1'b0;
          frc_d   = 1'b1;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign arb.grant_idx  = idx_q;
  assign arb.grant_en   = en_q;
  assign arb.forced_rel = frc_q;
  assign arb.busy       = en_q;

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// Scoreboard bench for rr_arbiter_4ch: expected grants (index, length, forced flag) are queued
// by each scenario and checked by a monitor when each grant ends.
module tb_rr_arbiter_4ch;

  logic clk;
  logic rst_n;
  rr_arbiter_4ch_if arb_if ();

  rr_arbiter_4ch #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb_if)
  );

  typedef struct {
    logic [1:0] idx;
    int         len;
    logic       frc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   mon_en = 1'b1;

  logic       prev_en;
  logic [1:0] run_idx;
  logic [1:0] hold_idx;
  int         run_len;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_en  = 1'b0;
      run_len  = 0;
      if (!rst_n) hold_idx = 2'b00;
    end else begin
      total_cnt++;
      if (arb_if.busy !== arb_if.grant_en)
        $display("FAIL busy: got %b want %b", arb_if.busy, arb_if.grant_en);
      else pass_cnt++;
      if (arb_if.grant_en === 1'b1) begin
        if (!prev_en) begin
          run_idx  = arb_if.grant_idx;
          hold_idx = arb_if.grant_idx;
          run_len  = 1;
        end else begin
          run_len++;
          total_cnt++;
          if (arb_if.grant_idx !== run_idx)
            $display("FAIL idx_stable: got %0d want %0d", arb_if.grant_idx, run_idx);
          else pass_cnt++;
        end
        total_cnt++;
        if (arb_if.forced_rel !== 1'b0)
          $display("FAIL forced_during_grant: got %b want 0", arb_if.forced_rel);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (arb_if.grant_idx !== hold_idx)
          $display("FAIL idx_hold_idle: got %0d want %0d", arb_if.grant_idx, hold_idx);
        else pass_cnt++;
        if (prev_en) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_grant: got idx %0d len %0d want none", run_idx, run_len);
          end else begin
            exp_t e;
            pass_cnt++;
            e = exp_q.pop_front();
            total_cnt++;
            if (run_idx !== e.idx)
              $display("FAIL grant_idx: got %0d want %0d", run_idx, e.idx);
            else pass_cnt++;
            total_cnt++;
            if (run_len != e.len)
              $display("FAIL grant_len: got %0d want %0d (idx %0d)", run_len, e.len, e.idx);
            else pass_cnt++;
            total_cnt++;
            if (arb_if.forced_rel !== e.frc)
              $display("FAIL forced_rel: got %b want %b (idx %0d)", arb_if.forced_rel, e.frc, e.idx);
            else pass_cnt++;
          end
        end else begin
          total_cnt++;
          if (arb_if.forced_rel !== 1'b0)
            $display("FAIL forced_idle: got %b want 0", arb_if.forced_rel);
          else pass_cnt++;
        end
      end
      prev_en = arb_if.grant_en;
    end
  end

  function automatic exp_t mk(input logic [1:0] idx, input int len, input logic frc);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.frc = frc;
    return e;
  endfunction

  task automatic do_reset();
    arb_if.req = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rise();
    logic tprev;
    bit   hit;
    tprev = arb_if.grant_en;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (arb_if.grant_en === 1'b1 && tprev !== 1'b1) hit = 1'b1;
      tprev = arb_if.grant_en;
    end
    if (!hit) begin
      total_cnt++;
      $display("FAIL wait_rise: got no grant want grant within 200 cycles");
    end
  endtask

  task automatic wait_fall();
    logic tprev;
    bit   hit;
    tprev = arb_if.grant_en;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (arb_if.grant_en === 1'b0 && tprev === 1'b1) hit = 1'b1;
      tprev = arb_if.grant_en;
    end
    if (!hit) begin
      total_cnt++;
      $display("FAIL wait_fall: got no release want release within 200 cycles");
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: got %0d pending want 0", name, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #3;
    total_cnt += 4;
    if (arb_if.grant_en !== 1'b0) $display("FAIL rst_en: got %b want 0", arb_if.grant_en); else pass_cnt++;
    if (arb_if.grant_idx !== 2'b00) $display("FAIL rst_idx: got %b want 00", arb_if.grant_idx); else pass_cnt++;
    if (arb_if.forced_rel !== 1'b0) $display("FAIL rst_frc: got %b want 0", arb_if.forced_rel); else pass_cnt++;
    if (arb_if.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", arb_if.busy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (arb_if.grant_en !== 1'b0) $display("FAIL idle_no_req: got %b want 0", arb_if.grant_en); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    exp_q.push_back(mk(2'd0, 3, 1'b0));
    arb_if.req = 4'b0001;
    @(negedge clk);
    total_cnt += 2;
    if (arb_if.grant_en !== 1'b1) $display("FAIL latency_en: got %b want 1", arb_if.grant_en); else pass_cnt++;
    if (arb_if.grant_idx !== 2'd0) $display("FAIL latency_idx: got %0d want 0", arb_if.grant_idx); else pass_cnt++;
    repeat (2) @(negedge clk);
    arb_if.req = 4'b0000;
    drain("single");
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    do_reset();
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(2'(k % 4), 2, 1'b0));
    arb_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 2'(k % 4);
      wait_rise();
      @(negedge clk);
      arb_if.req[g] = 1'b0;
      @(negedge clk);
      arb_if.req[g] = 1'b1;
    end
    arb_if.req = 4'b0000;
    drain("round_robin");
  endtask

  task automatic test_timeout();
    do_reset();
    exp_q.push_back(mk(2'd2, 8, 1'b1));
    exp_q.push_back(mk(2'd2, 8, 1'b1));
    arb_if.req = 4'b0100;
    wait_fall();
    @(negedge clk);
    total_cnt += 2;
    if (arb_if.grant_en !== 1'b1) $display("FAIL regrant_gap: got %b want 1", arb_if.grant_en); else pass_cnt++;
    if (arb_if.grant_idx !== 2'd2) $display("FAIL regrant_idx: got %0d want 2", arb_if.grant_idx); else pass_cnt++;
    wait_fall();
    arb_if.req = 4'b0000;
    drain("timeout");
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(2'(k % 2), 8, 1'b1));
    arb_if.req = 4'b0011;
    repeat (4) wait_fall();
    arb_if.req = 4'b0000;
    drain("fairness");
  endtask

  task automatic test_simultaneous();
    do_reset();
    exp_q.push_back(mk(2'd1, 2, 1'b0));
    exp_q.push_back(mk(2'd2, 2, 1'b0));
    exp_q.push_back(mk(2'd0, 2, 1'b0));
    arb_if.req = 4'b0010;
    wait_rise();
    @(negedge clk);
    arb_if.req = 4'b0101;
    wait_rise();
    @(negedge clk);
    arb_if.req = 4'b0001;
    wait_rise();
    @(negedge clk);
    arb_if.req = 4'b0000;
    drain("simultaneous");
  endtask

  task automatic test_release_on_timeout();
    do_reset();
    exp_q.push_back(mk(2'd3, 8, 1'b0));
    arb_if.req = 4'b1000;
    wait_rise();
    repeat (7) @(negedge clk);
    arb_if.req = 4'b0000;
    drain("release_on_timeout");
  endtask

  task automatic test_async_reset();
    mon_en = 1'b0;
    do_reset();
    arb_if.req = 4'b0100;
    wait_rise();
    total_cnt++;
    if (arb_if.grant_idx !== 2'd2) $display("FAIL pre_arst_idx: got %0d want 2", arb_if.grant_idx); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt += 4;
    if (arb_if.grant_en !== 1'b0) $display("FAIL arst_en: got %b want 0", arb_if.grant_en); else pass_cnt++;
    if (arb_if.grant_idx !== 2'b00) $display("FAIL arst_idx: got %b want 00", arb_if.grant_idx); else pass_cnt++;
    if (arb_if.forced_rel !== 1'b0) $display("FAIL arst_frc: got %b want 0", arb_if.forced_rel); else pass_cnt++;
    if (arb_if.busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", arb_if.busy); else pass_cnt++;
    arb_if.req = 4'b1111;
    #2 rst_n = 1'b1;
    @(negedge clk);
    total_cnt += 2;
    if (arb_if.grant_en !== 1'b1) $display("FAIL post_arst_en: got %b want 1", arb_if.grant_en); else pass_cnt++;
    if (arb_if.grant_idx !== 2'd0) $display("FAIL post_arst_idx: got %0d want 0", arb_if.grant_idx); else pass_cnt++;
    arb_if.req = 4'b0000;
    mon_en = 1'b1;
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    arb_if.req = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_fairness();
    test_simultaneous();
    test_release_on_timeout();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
